// File: rtl/alu_issue_unit.sv
// alu_issue_unit -- initiator side of a 32-bit combinational ALU.
//
// Accepts decoded-instruction requests (opcode/funct/rs/rt/imm) over a
// valid/ready handshake and decodes them into an ALU op and operands. The
// operands and op are registered onto alu_a/alu_b/alu_op. One cycle later the
// ALU result alu_z is captured and returned over a second valid/ready
// handshake, together with a zero flag, a branch-taken flag (beq/bne) and an
// illegal flag. Undecodable requests skip the ALU cycle and respond at once.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_opcode/funct/rs/rt/imm     decoded instruction fields
//   alu_a/alu_b/alu_op             registered ALU inputs
//   alu_z                          ALU result (combinational from alu_*)
//   rsp_valid/rsp_ready            response handshake
//   rsp_result/zero/taken/illegal  response payload
module alu_issue_unit #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [5:0]   req_opcode,
   input  logic [5:0]   req_funct,
   input  logic [W-1:0] req_rs,
   input  logic [W-1:0] req_rt,
   input  logic [15:0]  req_imm,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [W-1:0] alu_z,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_taken,
   output logic         rsp_illegal
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic         illegal;
      logic         beq;
      logic         bne;
      logic [2:0]   op;
      logic [W-1:0] b;
   } dec_t;

   state_t state, state_nxt;
   dec_t   dec;
   logic   accept;
   logic   is_beq, is_bne;

   logic [W-1:0] imm_sx, imm_zx;
   assign imm_sx = {{(W-16){req_imm[15]}}, req_imm};
   assign imm_zx = {{(W-16){1'b0}}, req_imm};

   // Decode: operand a is always rs, so only op, b and the flags vary.
   always_comb begin
      dec         = '0;
      dec.b       = req_rt;
      dec.op      = OP_ADD;
      unique case (req_opcode)
         6'h00: begin
            case (req_funct)
               6'h24:   dec.op = OP_AND;
               6'h25:   dec.op = OP_OR;
               6'h20:   dec.op = OP_ADD;
               6'h22:   dec.op = OP_SUB;
               6'h2A:   dec.op = OP_SLT;
               default: dec.illegal = 1'b1;
            endcase
         end
         6'h08, 6'h23, 6'h2B: begin dec.op = OP_ADD; dec.b = imm_sx; end
         6'h0C:   begin dec.op = OP_AND; dec.b = imm_zx; end
         6'h0D:   begin dec.op = OP_OR;  dec.b = imm_zx; end
         6'h0A:   begin dec.op = OP_SLT; dec.b = imm_sx; end
         6'h04:   begin dec.op = OP_SUB; dec.beq = 1'b1; end
         6'h05:   begin dec.op = OP_SUB; dec.bne = 1'b1; end
         default: dec.illegal = 1'b1;
      endcase
   end

   // A pending response that is being consumed frees the unit in the same
   // cycle, which is what makes back-to-back issue possible.
   assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = dec.illegal ? RESP : EXEC;
         EXEC: state_nxt = RESP;
         RESP: begin
            if (accept)         state_nxt = dec.illegal ? RESP : EXEC;
            else if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= OP_AND;
         is_beq      <= 1'b0;
         is_bne      <= 1'b0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_taken   <= 1'b0;
         rsp_illegal <= 1'b0;
      end else if (accept) begin
         if (dec.illegal) begin
            // No ALU cycle: alu_* keep their previous values.
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b1;
         end else begin
            alu_a  <= req_rs;
            alu_b  <= dec.b;
            alu_op <= dec.op;
            is_beq <= dec.beq;
            is_bne <= dec.bne;
         end
      end else if (state == EXEC) begin
         rsp_result  <= alu_z;
         rsp_zero    <= (alu_z == '0);
         rsp_taken   <= (is_beq && alu_z == '0) || (is_bne && alu_z != '0);
         rsp_illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed cases then randomized back-to-back
// traffic with random response backpressure, checked against an
// instruction-level reference model.
module tb_alu_issue_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [5:0]   req_opcode = '0;
   logic [5:0]   req_funct = '0;
   logic [W-1:0] req_rs = '0;
   logic [W-1:0] req_rt = '0;
   logic [15:0]  req_imm = '0;
   logic [W-1:0] alu_a, alu_b, alu_z;
   logic [2:0]   alu_op;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_result;
   logic         rsp_zero, rsp_taken, rsp_illegal;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_issue_unit #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct),
      .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
   );

   // External combinational ALU.
   always_comb begin
      case (alu_op)
         3'b000:  alu_z = alu_a & alu_b;
         3'b001:  alu_z = alu_a | alu_b;
         3'b010:  alu_z = alu_a + alu_b;
         3'b110:  alu_z = alu_a - alu_b;
         3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_z = '0;
      endcase
   end

   typedef struct {
      bit          legal;
      logic [2:0]  op;
      logic [31:0] b;
      logic [31:0] res;
      bit          taken;
   } exp_t;

   // Instruction semantics straight from the ISA view.
   function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [15:0] imm);
      exp_t e;
      logic [31:0] sx, zx;
      sx = {{16{imm[15]}}, imm};
      zx = {16'h0, imm};
      e.legal = 1; e.taken = 0; e.op = 3'b000; e.b = rt; e.res = 0;
      case (opc)
         6'h00: case (fn)
            6'h20: begin e.op = 3'b010; e.res = rs + rt; end
            6'h22: begin e.op = 3'b110; e.res = rs - rt; end
            6'h24: begin e.op = 3'b000; e.res = rs & rt; end
            6'h25: begin e.op = 3'b001; e.res = rs | rt; end
            6'h2A: begin e.op = 3'b111; e.res = ($signed(rs) < $signed(rt)) ? 1 : 0; end
            default: e.legal = 0;
         endcase
         6'h08, 6'h23, 6'h2B: begin e.op = 3'b010; e.b = sx; e.res = rs + sx; end
         6'h0C: begin e.op = 3'b000; e.b = zx; e.res = rs & zx; end
         6'h0D: begin e.op = 3'b001; e.b = zx; e.res = rs | zx; end
         6'h0A: begin e.op = 3'b111; e.b = sx; e.res = ($signed(rs) < $signed(sx)) ? 1 : 0; end
         6'h04: begin e.op = 3'b110; e.res = rs - rt; e.taken = (rs == rt); end
         6'h05: begin e.op = 3'b110; e.res = rs - rt; e.taken = (rs != rt); end
         default: e.legal = 0;
      endcase
      if (!e.legal) begin e.res = 0; e.taken = 0; end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bench-side record of what the registered ALU inputs should hold.
   logic [2:0]  last_op = 3'b000;
   logic [31:0] last_a = 0, last_b = 0;
   exp_t        cur;

   // Called at a negedge with the unit IDLE or in RESP; issues one request
   // (consuming any pending response on the same edge) and returns at the
   // negedge where the new response is visible, with rsp_ready low.
   task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm);
      cur = model(opc, fn, rs, rt, imm);
      req_valid = 1; req_opcode = opc; req_funct = fn;
      req_rs = rs; req_rt = rt; req_imm = imm; rsp_ready = 1;
      #1 chk("req_ready_at_issue", req_ready, 1);
      @(negedge clk);
      req_valid = 0; rsp_ready = 0;
      if (cur.legal) begin
         last_op = cur.op; last_a = rs; last_b = cur.b;
         chk("exec_rsp_valid", rsp_valid, 0);
         chk("exec_req_ready", req_ready, 0);
         chk("alu_a", alu_a, last_a);
         chk("alu_b", alu_b, last_b);
         chk("alu_op", alu_op, last_op);
         @(negedge clk);
      end else begin
         chk("illegal_alu_op_kept", alu_op, last_op);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, cur.res);
      chk("rsp_zero", rsp_zero, cur.legal && cur.res == 0);
      chk("rsp_taken", rsp_taken, cur.taken);
      chk("rsp_illegal", rsp_illegal, !cur.legal);
   endtask

   task automatic drain();
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("drain_rsp_valid", rsp_valid, 0);
      chk("drain_req_ready", req_ready, 1);
   endtask

   logic [5:0] opcs [12] = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h01};
   logic [5:0] fns  [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

   initial begin
      // Reset state, including req_ready while reset is held.
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", {rsp_zero, rsp_taken, rsp_illegal}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Directed cases.
      issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);                 // add
      issue(6'h08, 6'h00, 32'h10, 32'h0, 16'hFFFF);             // addi sext
      issue(6'h0C, 6'h00, 32'h10, 32'h0, 16'hFFFF);             // andi zext
      chk("andi_b", alu_b, 32'h0000FFFF);
      issue(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0);           // beq taken
      issue(6'h05, 6'h00, 32'h1234, 32'h1234, 16'h0);           // bne not
      issue(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0);          // slt signed
      chk("slt_result", rsp_result, 32'd1);
      drain();
      issue(6'h3F, 6'h00, 32'hDEAD, 32'hBEEF, 16'h1);           // illegal

      // Backpressure: response must hold while the consumer stalls, and a
      // waiting request must not be taken.
      issue(6'h00, 6'h22, 32'd3, 32'd9, 16'h0);
      req_valid = 1; req_opcode = 6'h00; req_funct = 6'h24;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_result", rsp_result, 32'd3 - 32'd9);
      end
      // Release with a request waiting: accepted on the same edge.
      issue(6'h00, 6'h25, 32'hF0, 32'h0F, 16'h0);

      // Reset during EXEC drops the in-flight op.
      rsp_ready = 1;
      req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20; req_rs = 1; req_rt = 2;
      @(negedge clk);
      req_valid = 0; rsp_ready = 0;
      chk("pre_rst_exec_valid", rsp_valid, 0);
      rst_n = 0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_alu_a", alu_a, 0);
      chk("midrst_alu_op", alu_op, 0);
      last_op = 0; last_a = 0; last_b = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);

      // Randomized back-to-back traffic with random stalls.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] rs, rt;
         rs = $urandom;
         rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
         if ($urandom_range(0, 2) == 0) rs = $urandom_range(0, 20);
         issue(opcs[$urandom_range(0, 11)], fns[$urandom_range(0, 5)],
               rs, rt, 16'($urandom));
         for (int s = $urandom_range(0, 2); s > 0; s--) begin
            @(negedge clk);
            chk("rnd_hold_valid", rsp_valid, 1);
            chk("rnd_hold_result", rsp_result, cur.res);
         end
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
